// File: rtl/cell_char_pkg.sv
// Shared definitions for the standard-cell characterisation sequencer:
// lane type codes, sequencer states and the per-lane golden function.
package cell_char_pkg;

  localparam logic [1:0] LT_BUF   = 2'd0;
  localparam logic [1:0] LT_INV   = 2'd1;
  localparam logic [1:0] LT_NAND2 = 2'd2;
  localparam logic [1:0] LT_NOR2  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_SAMPLE,
    ST_FIN
  } state_t;

  function automatic logic golden(input logic [1:0] lt, input logic a, input logic b);
    logic y;
    case (lt)
      LT_BUF:   y = a;
      LT_INV:   y = ~a;
      LT_NAND2: y = ~(a & b);
      default:  y = ~(a | b);
    endcase
    return y;
  endfunction

endpackage

// File: rtl/cell_char_golden.sv
// Combinational golden model: expected output of every lane for one A/B pair.
module cell_char_golden
  import cell_char_pkg::*;
#(
  parameter int unsigned        NCELLS    = 4,
  parameter logic [2*NCELLS-1:0] LANE_TYPE = '0
) (
  input  logic              a,
  input  logic              b,
  output logic [NCELLS-1:0] exp_y
);

  always_comb begin
    exp_y = '0;
    for (int unsigned i = 0; i < NCELLS; i++) begin
      exp_y[i] = golden(LANE_TYPE[2*i +: 2], a, b);
    end
  end

endmodule

// File: rtl/cell_char_sequencer.sv
// Functional self-test sequencer: walks AB through 00..11, waits SETTLE cycles,
// samples every lane and accumulates sticky fail flags and a saturating error count.
module cell_char_sequencer
  import cell_char_pkg::*;
#(
  parameter int unsigned         NCELLS    = 4,
  parameter logic [2*NCELLS-1:0] LANE_TYPE = {2'd3, 2'd2, 2'd1, 2'd0},
  parameter int unsigned         SETTLE    = 3,
  parameter int unsigned         ERRW      = 8
) (
  input  logic              CK,
  input  logic              R,
  input  logic              START,
  output logic [NCELLS-1:0] DUT_A,
  output logic [NCELLS-1:0] DUT_B,
  input  logic [NCELLS-1:0] DUT_Y,
  output logic              BUSY,
  output logic              DONE,
  output logic              PASS,
  output logic [NCELLS-1:0] FAIL_MASK,
  output logic [ERRW-1:0]   ERR_CNT
);

  localparam int unsigned SUMW = ERRW + 4;

  state_t            state, state_nxt;
  logic [1:0]        vec;
  logic [3:0]        settle_cnt;
  logic [NCELLS-1:0] exp_y;
  logic [NCELLS-1:0] mismatch;
  logic [NCELLS-1:0] mask_nxt;
  logic [3:0]        n_mis;
  logic [SUMW-1:0]   err_sum;
  logic [ERRW-1:0]   err_nxt;

  cell_char_golden #(
    .NCELLS    (NCELLS),
    .LANE_TYPE (LANE_TYPE)
  ) u_golden (
    .a     (vec[1]),
    .b     (vec[0]),
    .exp_y (exp_y)
  );

  always_comb begin
    state_nxt = state;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    case (state)
      ST_IDLE:   if (START) state_nxt = ST_APPLY;
      ST_APPLY:  begin
        BUSY      = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT:   begin
        BUSY = 1'b1;
        if (settle_cnt == 4'd1) state_nxt = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        BUSY      = 1'b1;
        state_nxt = (vec == 2'd3) ? ST_FIN : ST_APPLY;
      end
      ST_FIN:    begin
        DONE      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Case inequality so an undriven (X/Z) lane output is scored as a failure.
  always_comb begin
    mismatch = '0;
    n_mis    = '0;
    for (int unsigned i = 0; i < NCELLS; i++) begin
      mismatch[i] = (DUT_Y[i] !== exp_y[i]);
      n_mis       = n_mis + 4'(mismatch[i]);
    end
    mask_nxt = FAIL_MASK | mismatch;
    err_sum  = SUMW'(ERR_CNT) + SUMW'(n_mis);
    if (err_sum[SUMW-1:ERRW] != '0) err_nxt = '1;
    else                            err_nxt = err_sum[ERRW-1:0];
  end

  always_ff @(posedge CK) begin
    if (R) state <= ST_IDLE;
    else   state <= state_nxt;
  end

  always_ff @(posedge CK) begin
    if (R) begin
      vec        <= '0;
      settle_cnt <= '0;
      DUT_A      <= '0;
      DUT_B      <= '0;
      FAIL_MASK  <= '0;
      ERR_CNT    <= '0;
      PASS       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: if (START) begin
          vec       <= '0;
          FAIL_MASK <= '0;
          ERR_CNT   <= '0;
          PASS      <= 1'b0;
        end
        ST_APPLY: begin
          DUT_A      <= {NCELLS{vec[1]}};
          DUT_B      <= {NCELLS{vec[0]}};
          settle_cnt <= 4'(SETTLE);
        end
        ST_WAIT: settle_cnt <= settle_cnt - 4'd1;
        ST_SAMPLE: begin
          FAIL_MASK <= mask_nxt;
          ERR_CNT   <= err_nxt;
          // PASS is taken from the post-update mask so it is valid while DONE is high.
          if (vec == 2'd3) PASS <= (mask_nxt == '0);
          else             vec  <= vec + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cell_char_sequencer.sv
// Directed bench for cell_char_sequencer: three instances (default, ERRW=2,
// SETTLE=1) driven by a behavioural lane model with selectable faults.
module tb_cell_char_sequencer;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic       r0, r1, r2, st0, st1, st2;
  logic [3:0] ua0, ub0, y0, fm0, ua1, ub1, y1, fm1, ua2, ub2, y2, fm2;
  logic       busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
  logic [7:0] err0, err2;
  logic [1:0] err1;
  logic [3:0] a_d2, b_d2;
  int         fault0, fault1, fault2;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic       busy, done, pass;
    logic [3:0] a, b, mask;
    logic [7:0] err;
  } obs_t;

  typedef struct {
    int         fault;
    logic [3:0] mask;
    logic [7:0] err;
    logic       pass;
    string      tag;
  } vec_t;

  // Lane 0 BUF, 1 INV, 2 NAND2, 3 NOR2. Mode 2 uses an always-wrong lane 0 to
  // stand in for a floating (X) output, which a 2-state simulator cannot hold.
  function automatic logic [3:0] model_y(input int mode, input logic [3:0] a, input logic [3:0] b);
    logic [3:0] g;
    g[0] = a[0];
    g[1] = ~a[1];
    g[2] = ~(a[2] & b[2]);
    g[3] = ~(a[3] | b[3]);
    case (mode)
      1: g[2] = 1'b0;
      2: begin g[0] = ~g[0]; g[3] = ~g[3]; end
      3: g = ~g;
      4: g[1] = 1'b1;
      default: ;
    endcase
    return g;
  endfunction

  always @(posedge ck) begin
    a_d2 <= ua2;
    b_d2 <= ub2;
  end

  assign y0 = model_y(fault0, ua0, ub0);
  assign y1 = model_y(fault1, ua1, ub1);
  // Mode 5: lane outputs lag their inputs by one clock.
  assign y2 = (fault2 == 5) ? model_y(0, a_d2, b_d2) : model_y(fault2, ua2, ub2);

  cell_char_sequencer u0 (
    .CK(ck), .R(r0), .START(st0), .DUT_A(ua0), .DUT_B(ub0), .DUT_Y(y0),
    .BUSY(busy0), .DONE(done0), .PASS(pass0), .FAIL_MASK(fm0), .ERR_CNT(err0)
  );

  cell_char_sequencer #(.ERRW(2)) u1 (
    .CK(ck), .R(r1), .START(st1), .DUT_A(ua1), .DUT_B(ub1), .DUT_Y(y1),
    .BUSY(busy1), .DONE(done1), .PASS(pass1), .FAIL_MASK(fm1), .ERR_CNT(err1)
  );

  cell_char_sequencer #(.SETTLE(1)) u2 (
    .CK(ck), .R(r2), .START(st2), .DUT_A(ua2), .DUT_B(ub2), .DUT_Y(y2),
    .BUSY(busy2), .DONE(done2), .PASS(pass2), .FAIL_MASK(fm2), .ERR_CNT(err2)
  );

  function automatic obs_t obs(input int k);
    obs_t o;
    case (k)
      0: begin o.busy = busy0; o.done = done0; o.pass = pass0; o.a = ua0; o.b = ub0; o.mask = fm0; o.err = err0; end
      1: begin o.busy = busy1; o.done = done1; o.pass = pass1; o.a = ua1; o.b = ub1; o.mask = fm1; o.err = {6'd0, err1}; end
      default: begin o.busy = busy2; o.done = done2; o.pass = pass2; o.a = ua2; o.b = ub2; o.mask = fm2; o.err = err2; end
    endcase
    return o;
  endfunction

  task automatic set_start(input int k, input logic v);
    case (k)
      0: st0 = v;
      1: st1 = v;
      default: st2 = v;
    endcase
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One full run: START sampled at edge 0, cycle c is the interval after edge c-1.
  task automatic run(input int k, input int settle, input logic [3:0] exp_mask,
                     input logic [7:0] exp_err, input logic exp_pass, input string tag);
    obs_t o;
    int dc;
    int v;
    int per;
    int exp_done;
    per      = settle + 2;
    exp_done = 1 + 4 * per;
    dc       = 0;
    @(posedge ck); #1 set_start(k, 1'b1);
    @(posedge ck); #1 set_start(k, 1'b0);
    for (int c = 1; c <= 60 && dc == 0; c++) begin
      @(negedge ck);
      o = obs(k);
      if (c >= 2 && c <= exp_done) begin
        v = (c - 2) / per;
        check({tag, "_ab"}, {24'd0, o.a, o.b}, {24'd0, {4{v[1]}}, {4{v[0]}}});
      end
      check({tag, "_busy"}, {31'd0, o.busy}, (c < exp_done) ? 32'd1 : 32'd0);
      if (o.done) dc = c;
    end
    check({tag, "_done_cycle"}, dc, exp_done);
    check({tag, "_mask"}, {28'd0, o.mask}, {28'd0, exp_mask});
    check({tag, "_err"}, {24'd0, o.err}, {24'd0, exp_err});
    check({tag, "_pass"}, {31'd0, o.pass}, {31'd0, exp_pass});
    @(negedge ck);
    o = obs(k);
    check({tag, "_done_pulse"}, {31'd0, o.done}, 32'd0);
    check({tag, "_hold"}, {23'd0, o.pass, o.a, o.b}, {23'd0, exp_pass, 8'hf0 | 8'h0f});
  endtask

  vec_t tbl[6];

  initial begin
    obs_t o;
    tbl[0] = '{0, 4'b0000, 8'd0,  1'b1, "ideal"};
    tbl[1] = '{1, 4'b0100, 8'd3,  1'b0, "nand_sa0"};
    tbl[2] = '{2, 4'b1001, 8'd8,  1'b0, "buf_x_nor_inv"};
    tbl[3] = '{4, 4'b0010, 8'd2,  1'b0, "inv_sa1"};
    tbl[4] = '{3, 4'b1111, 8'd16, 1'b0, "all_inv"};
    tbl[5] = '{0, 4'b0000, 8'd0,  1'b1, "ideal_again"};

    r0 = 1'b1; r1 = 1'b1; r2 = 1'b1;
    st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
    fault0 = 0; fault1 = 0; fault2 = 0;
    repeat (3) @(posedge ck);
    @(negedge ck);
    for (int k = 0; k < 3; k++) begin
      o = obs(k);
      check("reset_state", {9'd0, o.busy, o.done, o.pass, o.a, o.b, o.mask, o.err},
            32'd0);
    end
    @(posedge ck); #1 r0 = 1'b0; r1 = 1'b0; r2 = 1'b0;

    for (int i = 0; i < 6; i++) begin
      fault0 = tbl[i].fault;
      run(0, 3, tbl[i].mask, tbl[i].err, tbl[i].pass, tbl[i].tag);
    end

    // Re-START mid-run is ignored; reset mid-run aborts without DONE.
    fault0 = 3;
    @(posedge ck); #1 st0 = 1'b1;
    @(posedge ck); #1 st0 = 1'b0;
    for (int c = 1; c <= 13; c++) begin
      st0 = (c == 8);
      r0  = (c == 12);
      @(negedge ck);
      o = obs(0);
      check("abort_no_done", {31'd0, o.done}, 32'd0);
      if (c == 12) begin
        check("abort_ab_c12", {24'd0, o.a, o.b}, 32'h000000f0);
        check("abort_mask_c12", {28'd0, o.mask}, 32'hf);
        check("abort_err_c12", {24'd0, o.err}, 32'd8);
      end
      if (c == 13) begin
        check("abort_busy", {31'd0, o.busy}, 32'd0);
        check("abort_ab", {24'd0, o.a, o.b}, 32'd0);
        check("abort_mask", {28'd0, o.mask}, 32'd0);
        check("abort_err", {24'd0, o.err}, 32'd0);
      end
      @(posedge ck); #1;
    end
    st0 = 1'b0;
    r0  = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge ck);
      check("abort_idle_done", {30'd0, done0, busy0}, 32'd0);
    end
    fault0 = 0;
    run(0, 3, 4'b0000, 8'd0, 1'b1, "after_abort");

    fault1 = 3;
    run(1, 3, 4'b1111, 8'd3, 1'b0, "errw2_sat");
    fault1 = 0;
    run(1, 3, 4'b0000, 8'd0, 1'b1, "errw2_ideal");

    fault2 = 5;
    run(2, 1, 4'b0000, 8'd0, 1'b1, "settle1_lag");
    fault2 = 3;
    run(2, 1, 4'b1111, 8'd16, 1'b0, "settle1_inv");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
